mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline. It sits between the EX/MEM register and the write-back stage and drives the data-memory request/response interface. It performs store byte-lane steering and load extraction with sign/zero extension, then registers the result into the `memwb_t` bundle consumed by write-back. A two-state FSM stalls the upstream pipeline while a memory transaction is outstanding.

---
 rtl/pipeline_pkg.sv | 65 ++++++
 rtl/mem_stage_load_extend.sv | 41 ++++
 rtl/mem_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_stage.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared types and constants for the five-stage pipeline memory stage.
//   PIPE_XLEN      : datapath width (only 32 is supported)
//   RESULT_LOAD    : ResultSrc encoding that marks a load
//   F3_*           : funct3 access-size encodings (shared by loads and stores)
//   mem_state_t    : memory-stage FSM state
//   exmem_t        : EX/MEM register bundle
//   memwb_t        : MEM/WB register bundle
//   is_misaligned  : alignment check used when MEM_MISALIGN_TRAP_EN is defined
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int PIPE_XLEN = 32;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic                 valid;
        logic [PIPE_XLEN-1:0] ALUResult;
        logic [PIPE_XLEN-1:0] WriteData;
        logic [PIPE_XLEN-1:0] PCPlus4;
        logic [PIPE_XLEN-1:0] ImmExt;
        logic [1:0]           ResultSrc;
        logic [4:0]           Rd;
        logic                 RegWrite;
        logic                 MemWrite;
        logic [2:0]           funct3;
    } exmem_t;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] ALUResult;
        logic [PIPE_XLEN-1:0] load_data;
        logic [PIPE_XLEN-1:0] PCPlus4;
        logic [PIPE_XLEN-1:0] ImmExt;
        logic [1:0]           ResultSrc;
        logic [4:0]           Rd;
        logic                 RegWrite;
    } memwb_t;

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_H, F3_HU: bad = offset[0];
            F3_W:        bad = (offset != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational load extraction: picks the addressed byte/halfword out of the
// raw memory word and sign- or zero-extends it according to funct3.
//   rdata  in  XLEN  raw load word from data memory
//   offset in  2     byte offset of the access within the word
//   funct3 in  3     access size / signedness (LB, LH, LW, LBU, LHU)
//   result out XLEN  extended load value
// Halfword lanes are chosen by offset[1] only, so an odd offset wraps within
// the word instead of straddling it.
// ---------------------------------------------------------------------------
module load_extend
    import pipeline_pkg::*;
#(
    parameter int XLEN = PIPE_XLEN
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = rdata[{offset[1], 4'b0000} +: 16];
        result   = rdata;
        case (funct3)
            F3_B:    result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_BU:   result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H:    result = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_HU:   result = {{(XLEN-16){1'b0}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access stage between EX/MEM and write-back. Drives the data-memory
// request/response interface, steers store data onto byte lanes, extracts
// and extends load data, and registers the MEM/WB bundle. A two-state FSM
// (IDLE / WAIT_RSP) holds the upstream pipeline while a load is outstanding.
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   reset        in   asynchronous, active-high
//   inputs       in   exmem_t EX/MEM bundle
//   dmem_req     out  request valid
//   dmem_we      out  1 = store, 0 = load
//   dmem_addr    out  word-aligned address
//   dmem_be      out  byte enables
//   dmem_wdata   out  lane-steered store data
//   dmem_ready   in   memory accepts the request this cycle
//   dmem_rvalid  in   load data valid
//   dmem_rdata   in   raw load word
//   misalignM    out  misaligned-access flag (only with MEM_MISALIGN_TRAP_EN)
//   StallM       out  freeze IF/ID/EX and the EX/MEM register
//   outputs      out  memwb_t registered MEM/WB bundle
//
// Build option MEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses issue
// no request and leave as a bubble flagged by misalignM. Without it, the low
// address bits simply wrap within the word.
// ---------------------------------------------------------------------------
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN = PIPE_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  exmem_t          inputs,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic            misalignM,
`endif
    output logic            StallM,
    output memwb_t          outputs
);

    mem_state_t      state;
    mem_state_t      state_next;
    logic            is_load;
    logic            is_store;
    logic            misaligned;
    logic            load_accept;
    logic            rsp_done;
    logic [1:0]      offset_q;
    logic [XLEN-1:0] ext_data;
    memwb_t          wb_next;

    assign is_load  = inputs.valid && (inputs.ResultSrc == RESULT_LOAD);
    assign is_store = inputs.valid && inputs.MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = (state == IDLE) && (is_load || is_store)
                        && is_misaligned(inputs.funct3, inputs.ALUResult[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // Reset gates the request so nothing escapes while the stage is held.
    assign dmem_req    = !reset && (state == IDLE) && (is_load || is_store) && !misaligned;
    assign dmem_we     = is_store;
    assign dmem_addr   = {inputs.ALUResult[XLEN-1:2], 2'b00};
    assign load_accept = dmem_req && dmem_ready && !dmem_we;
    assign rsp_done    = (state == WAIT_RSP) && dmem_rvalid;

    // Store lane steering; the 4-bit shift result drops lanes past byte 3,
    // which is how an odd halfword wraps inside the word.
    always_comb begin
        dmem_wdata = inputs.WriteData;
        dmem_be    = 4'b1111;
        case (inputs.funct3[1:0])
            2'b00: begin
                dmem_wdata = {4{inputs.WriteData[7:0]}};
                dmem_be    = 4'b0001 << inputs.ALUResult[1:0];
            end
            2'b01: begin
                dmem_wdata = {2{inputs.WriteData[15:0]}};
                dmem_be    = 4'b0011 << inputs.ALUResult[1:0];
            end
            default: begin
                dmem_wdata = inputs.WriteData;
                dmem_be    = 4'b1111;
            end
        endcase
    end

    // Next state and stall. A load stalls in its accept cycle too: its data
    // only exists once rvalid arrives, so the slot must not advance yet.
    always_comb begin
        state_next = state;
        StallM     = 1'b0;
        case (state)
            IDLE: begin
                StallM = dmem_req && (!dmem_ready || !dmem_we);
                if (load_accept) state_next = WAIT_RSP;
            end
            WAIT_RSP: begin
                StallM = !dmem_rvalid;
                if (dmem_rvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            offset_q <= 2'b00;
        end else begin
            state <= state_next;
            if (load_accept) offset_q <= inputs.ALUResult[1:0];
        end
    end

    // The EX/MEM register is frozen while waiting, so funct3 is still the
    // load's own; only the byte offset needs capturing at accept.
    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata  (dmem_rdata),
        .offset (offset_q),
        .funct3 (inputs.funct3),
        .result (ext_data)
    );

    // A stalled or trapped slot becomes an all-zero bubble so write-back
    // never sees the same instruction twice.
    always_comb begin
        wb_next = '0;
        if (!StallM && !misaligned) begin
            wb_next.ALUResult = inputs.ALUResult;
            wb_next.load_data = rsp_done ? ext_data : '0;
            wb_next.PCPlus4   = inputs.PCPlus4;
            wb_next.ImmExt    = inputs.ImmExt;
            wb_next.ResultSrc = inputs.ResultSrc;
            wb_next.Rd        = inputs.Rd;
            wb_next.RegWrite  = inputs.valid && inputs.RegWrite;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outputs <= '0;
        end else begin
            outputs <= wb_next;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalignM <= 1'b0;
        end else begin
            misalignM <= misaligned;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Directed self-checking bench for mem_stage and a standalone load_extend.
// ---------------------------------------------------------------------------
module tb_mem_stage;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    exmem_t      ex;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        StallM;
    memwb_t      outputs;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalignM;
`endif

    logic [31:0] le_rdata;
    logic [1:0]  le_offset;
    logic [2:0]  le_f3;
    logic [31:0] le_result;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk         (clk),
        .reset       (reset),
        .inputs      (ex),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_ready  (dmem_ready),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalignM   (misalignM),
`endif
        .StallM      (StallM),
        .outputs     (outputs)
    );

    load_extend u_le (
        .rdata  (le_rdata),
        .offset (le_offset),
        .funct3 (le_f3),
        .result (le_result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exmem_t mk_load(input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [4:0] rd);
        exmem_t e;
        e           = '0;
        e.valid     = 1'b1;
        e.ALUResult = addr;
        e.PCPlus4   = 32'h0000_0080;
        e.ResultSrc = RESULT_LOAD;
        e.Rd        = rd;
        e.RegWrite  = 1'b1;
        e.funct3    = f3;
        return e;
    endfunction

    function automatic exmem_t mk_store(input logic [2:0] f3, input logic [31:0] addr,
                                        input logic [31:0] wd);
        exmem_t e;
        e           = '0;
        e.valid     = 1'b1;
        e.ALUResult = addr;
        e.WriteData = wd;
        e.MemWrite  = 1'b1;
        e.funct3    = f3;
        return e;
    endfunction

    // ---------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; dmem_ready = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = '0;
        ex = mk_load(F3_W, 32'h0000_0100, 5'd3);
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b want 0", dmem_req); end
        n_cmp++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", StallM); end
        tick();
        n_cmp++; if (outputs !== '0) begin n_fail++; $display("FAIL rst_outputs: got %h want 0", outputs); end
        reset = 1'b0;
        #1;
        n_cmp++; if (StallM !== 1'b1) begin n_fail++; $display("FAIL rst_load_stall: got %0b want 1", StallM); end
        tick();
        n_cmp++; if (dut.state !== WAIT_RSP) begin n_fail++; $display("FAIL rst_in_wait: got %0d want WAIT_RSP", dut.state); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL rst_async_state: got %0d want IDLE", dut.state); end
        n_cmp++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL rst_async_stall: got %0b want 0", StallM); end
        n_cmp++; if (outputs.RegWrite !== 1'b0) begin n_fail++; $display("FAIL rst_async_regwrite: got %0b want 0", outputs.RegWrite); end
        tick();
        reset = 1'b0; ex = '0; dmem_ready = 1'b0;
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        #1;
        n_cmp++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL late_rvalid_stall: got %0b want 0", StallM); end
        tick();
        n_cmp++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL late_rvalid_state: got %0d want IDLE", dut.state); end
        n_cmp++; if (outputs.RegWrite !== 1'b0) begin n_fail++; $display("FAIL late_rvalid_regwrite: got %0b want 0", outputs.RegWrite); end
        n_cmp++; if (outputs.load_data !== 32'h0) begin n_fail++; $display("FAIL late_rvalid_data: got %h want 0", outputs.load_data); end
        dmem_rvalid = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic run_store(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] exp_addr,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd);
        ex = mk_store(f3, addr, wd); dmem_ready = 1'b1;
        #1;
        n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin n_fail++; $display("FAIL %s_req: got req=%0b we=%0b want 1/1", nm, dmem_req, dmem_we); end
        n_cmp++; if (dmem_addr !== exp_addr) begin n_fail++; $display("FAIL %s_addr: got %h want %h", nm, dmem_addr, exp_addr); end
        n_cmp++; if (dmem_be !== exp_be) begin n_fail++; $display("FAIL %s_be: got %b want %b", nm, dmem_be, exp_be); end
        n_cmp++; if (dmem_wdata !== exp_wd) begin n_fail++; $display("FAIL %s_wdata: got %h want %h", nm, dmem_wdata, exp_wd); end
        n_cmp++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL %s_stall: got %0b want 0", nm, StallM); end
        tick();
        n_cmp++; if (outputs.ALUResult !== addr || outputs.RegWrite !== 1'b0) begin n_fail++; $display("FAIL %s_wb: got alu=%h rw=%0b want %h/0", nm, outputs.ALUResult, outputs.RegWrite, addr); end
        n_cmp++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL %s_state: got %0d want IDLE", nm, dut.state); end
        ex = '0;
    endtask

    task automatic test_store();
        run_store("sb3", F3_B, 32'h0000_1003, 32'h0000_00AB, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB);
        run_store("sb1", F3_B, 32'h0000_1001, 32'h1234_5655, 32'h0000_1000, 4'b0010, 32'h5555_5555);
        run_store("sh2", F3_H, 32'h0000_1002, 32'h1234_BEEF, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF);
        run_store("sw",  F3_W, 32'h0000_1004, 32'hCAFE_1234, 32'h0000_1004, 4'b1111, 32'hCAFE_1234);
`ifndef MEM_MISALIGN_TRAP_EN
        run_store("sh3_wrap", F3_H, 32'h0000_1003, 32'h0000_7777, 32'h0000_1000, 4'b1000, 32'h7777_7777);
        run_store("sw1_wrap", F3_W, 32'h0000_1005, 32'h0102_0304, 32'h0000_1004, 4'b1111, 32'h0102_0304);
`endif
        // Store held off by memory for one cycle.
        ex = mk_store(F3_W, 32'h0000_1010, 32'h5A5A_5A5A); dmem_ready = 1'b0;
        #1;
        n_cmp++; if (StallM !== 1'b1) begin n_fail++; $display("FAIL st_wait_stall: got %0b want 1", StallM); end
        tick();
        n_cmp++; if (outputs !== '0) begin n_fail++; $display("FAIL st_wait_bubble: got %h want 0", outputs); end
        dmem_ready = 1'b1;
        #1;
        n_cmp++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL st_accept_stall: got %0b want 0", StallM); end
        tick();
        ex = '0;
    endtask

    // ---------------------------------------------------------------------
    task automatic run_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        ex = mk_load(f3, addr, 5'd7); dmem_ready = 1'b1; dmem_rvalid = 1'b0;
        #1;
        n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL %s_req: got req=%0b we=%0b want 1/0", nm, dmem_req, dmem_we); end
        n_cmp++; if (dmem_addr !== {addr[31:2], 2'b00}) begin n_fail++; $display("FAIL %s_addr: got %h want %h", nm, dmem_addr, {addr[31:2], 2'b00}); end
        n_cmp++; if (StallM !== 1'b1) begin n_fail++; $display("FAIL %s_accept_stall: got %0b want 1", nm, StallM); end
        tick();
        n_cmp++; if (outputs !== '0) begin n_fail++; $display("FAIL %s_bubble: got %h want 0", nm, outputs); end
        dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
        #1;
        n_cmp++; if (StallM !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL %s_rsp: got stall=%0b req=%0b want 0/0", nm, StallM, dmem_req); end
        tick();
        n_cmp++; if (outputs.load_data !== exp) begin n_fail++; $display("FAIL %s_data: got %h want %h", nm, outputs.load_data, exp); end
        n_cmp++; if (outputs.RegWrite !== 1'b1 || outputs.Rd !== 5'd7) begin n_fail++; $display("FAIL %s_wb: got rw=%0b rd=%0d want 1/7", nm, outputs.RegWrite, outputs.Rd); end
        ex = '0; dmem_rvalid = 1'b0;
    endtask

    task automatic test_load_zero_wait();
        run_load("lb2",  F3_B,  32'h0000_2002, 32'h1280_FF34, 32'hFFFF_FF80);
        run_load("lbu2", F3_BU, 32'h0000_2002, 32'h1280_FF34, 32'h0000_0080);
        run_load("lb1",  F3_B,  32'h0000_2001, 32'h1280_FF34, 32'hFFFF_FFFF);
        run_load("lh0",  F3_H,  32'h0000_2000, 32'h1280_FF34, 32'hFFFF_FF34);
        run_load("lhu2", F3_HU, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001);
`ifndef MEM_MISALIGN_TRAP_EN
        run_load("lh3_wrap", F3_H, 32'h0000_2003, 32'h8001_0000, 32'hFFFF_8001);
`endif
    endtask

    // ---------------------------------------------------------------------
    task automatic test_wait_states();
        int stalls  = 0;
        int bubbles = 0;
        ex = mk_load(F3_W, 32'h0000_3008, 5'd9); dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ready = 1'b1;
            #1;
            n_cmp++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_3008) begin n_fail++; $display("FAIL ws_hold%0d: got req=%0b addr=%h want 1/00003008", i, dmem_req, dmem_addr); end
            if (StallM === 1'b1) stalls++;
            tick();
            if (outputs === '0) bubbles++;
        end
        dmem_ready = 1'b0;
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL ws_wait_req: got %0b want 0", dmem_req); end
        if (StallM === 1'b1) stalls++;
        tick();
        if (outputs === '0) bubbles++;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        if (StallM === 1'b1) stalls++;
        tick();
        n_cmp++; if (stalls != 5) begin n_fail++; $display("FAIL ws_stall_cycles: got %0d want 5", stalls); end
        n_cmp++; if (bubbles != 5) begin n_fail++; $display("FAIL ws_bubbles: got %0d want 5", bubbles); end
        n_cmp++; if (outputs.RegWrite !== 1'b1 || outputs.Rd !== 5'd9) begin n_fail++; $display("FAIL ws_wb: got rw=%0b rd=%0d want 1/9", outputs.RegWrite, outputs.Rd); end
        n_cmp++; if (outputs.load_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ws_data: got %h want deadbeef", outputs.load_data); end
        ex = '0; dmem_rvalid = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_alu();
        ex = '0;
        ex.valid = 1'b1; ex.ALUResult = 32'h42; ex.PCPlus4 = 32'h104; ex.ImmExt = 32'h10;
        ex.Rd = 5'd5; ex.RegWrite = 1'b1; ex.ResultSrc = 2'b00;
        dmem_ready = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (dmem_req !== 1'b0 || StallM !== 1'b0) begin n_fail++; $display("FAIL alu_req: got req=%0b stall=%0b want 0/0", dmem_req, StallM); end
        tick();
        n_cmp++; if (outputs.ALUResult !== 32'h42 || outputs.Rd !== 5'd5 || outputs.RegWrite !== 1'b1) begin n_fail++; $display("FAIL alu_wb: got alu=%h rd=%0d rw=%0b want 42/5/1", outputs.ALUResult, outputs.Rd, outputs.RegWrite); end
        n_cmp++; if (outputs.load_data !== 32'h0 || outputs.PCPlus4 !== 32'h104 || outputs.ImmExt !== 32'h10) begin n_fail++; $display("FAIL alu_fields: got ld=%h pc4=%h imm=%h want 0/104/10", outputs.load_data, outputs.PCPlus4, outputs.ImmExt); end
        ex.ResultSrc = 2'b10; ex.Rd = 5'd1;
        tick();
        n_cmp++; if (outputs.ResultSrc !== 2'b10 || outputs.Rd !== 5'd1) begin n_fail++; $display("FAIL jal_wb: got rs=%b rd=%0d want 10/1", outputs.ResultSrc, outputs.Rd); end
        // Invalid slot carrying load-looking fields.
        ex.valid = 1'b0; ex.ResultSrc = RESULT_LOAD; ex.Rd = 5'd6;
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL inv_req: got %0b want 0", dmem_req); end
        tick();
        n_cmp++; if (outputs.RegWrite !== 1'b0) begin n_fail++; $display("FAIL inv_regwrite: got %0b want 0", outputs.RegWrite); end
        ex = '0; dmem_rvalid = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_back_to_back();
        ex = mk_load(F3_W, 32'h0000_4000, 5'd10); dmem_ready = 1'b1; dmem_rvalid = 1'b0;
        tick();
        dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1122_3344;
        tick();
        n_cmp++; if (outputs.load_data !== 32'h1122_3344 || outputs.Rd !== 5'd10) begin n_fail++; $display("FAIL b2b_first: got %h rd=%0d want 11223344/10", outputs.load_data, outputs.Rd); end
        ex = mk_load(F3_HU, 32'h0000_4006, 5'd11); dmem_ready = 1'b1; dmem_rvalid = 1'b0;
        #1;
        n_cmp++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_4004 || StallM !== 1'b1) begin n_fail++; $display("FAIL b2b_second_req: got req=%0b addr=%h stall=%0b want 1/00004004/1", dmem_req, dmem_addr, StallM); end
        tick();
        dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hABCD_0000;
        tick();
        n_cmp++; if (outputs.load_data !== 32'h0000_ABCD || outputs.Rd !== 5'd11) begin n_fail++; $display("FAIL b2b_second: got %h rd=%0d want 0000abcd/11", outputs.load_data, outputs.Rd); end
        ex = '0; dmem_rvalid = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_load_extend();
        le_rdata = 32'h1280_FF34;
        le_f3 = F3_B;  le_offset = 2'd1; #1;
        n_cmp++; if (le_result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL le_lb1: got %h want ffffffff", le_result); end
        le_f3 = F3_BU; le_offset = 2'd3; #1;
        n_cmp++; if (le_result !== 32'h0000_0012) begin n_fail++; $display("FAIL le_lbu3: got %h want 00000012", le_result); end
        le_f3 = F3_H;  le_offset = 2'd2; #1;
        n_cmp++; if (le_result !== 32'h0000_1280) begin n_fail++; $display("FAIL le_lh2: got %h want 00001280", le_result); end
        le_f3 = F3_HU; le_offset = 2'd0; #1;
        n_cmp++; if (le_result !== 32'h0000_FF34) begin n_fail++; $display("FAIL le_lhu0: got %h want 0000ff34", le_result); end
        le_f3 = F3_H;  le_offset = 2'd1; #1;
        n_cmp++; if (le_result !== 32'hFFFF_FF34) begin n_fail++; $display("FAIL le_lh1_wrap: got %h want ffffff34", le_result); end
        le_f3 = F3_W;  le_offset = 2'd2; #1;
        n_cmp++; if (le_result !== 32'h1280_FF34) begin n_fail++; $display("FAIL le_lw: got %h want 1280ff34", le_result); end
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign();
        ex = mk_load(F3_W, 32'h0000_3002, 5'd12); dmem_ready = 1'b1; dmem_rvalid = 1'b0;
        #1;
        n_cmp++; if (dmem_req !== 1'b0 || StallM !== 1'b0) begin n_fail++; $display("FAIL mis_lw_req: got req=%0b stall=%0b want 0/0", dmem_req, StallM); end
        tick();
        n_cmp++; if (misalignM !== 1'b1 || outputs.RegWrite !== 1'b0) begin n_fail++; $display("FAIL mis_lw_flag: got mis=%0b rw=%0b want 1/0", misalignM, outputs.RegWrite); end
        ex = mk_store(F3_H, 32'h0000_1001, 32'h1234);
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL mis_sh_req: got %0b want 0", dmem_req); end
        tick();
        ex = '0;
        tick();
        n_cmp++; if (misalignM !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %0b want 0", misalignM); end
    endtask
`endif

    // ---------------------------------------------------------------------
    initial begin
        ex = '0; reset = 1'b1; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        le_rdata = '0; le_offset = '0; le_f3 = '0;
        test_reset();
        test_store();
        test_load_zero_wait();
        test_wait_states();
        test_alu();
        test_back_to_back();
        test_load_extend();
`ifdef MEM_MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
